// File: rtl/mole_field_renderer_if.sv
// Pixel-write bundle between the game logic, the mole field renderer and vga_adapter.
// The renderer takes the slave side, and whoever drives start/hole takes the master side.
interface mole_field_renderer_if #(
  parameter int X_W       = 9,
  parameter int Y_W       = 8,
  parameter int COLOR_W   = 3,
  parameter int NUM_HOLES = 8
);
  logic                 i_start;
  logic [NUM_HOLES-1:0] i_hole;
  logic [X_W-1:0]       o_x;
  logic [Y_W-1:0]       o_y;
  logic [COLOR_W-1:0]   o_color;
  logic                 o_plot;
  logic                 o_busy;
  logic                 o_done;

  modport master (
    output i_start, i_hole,
    input  o_x, o_y, o_color, o_plot, o_busy, o_done
  );

  modport slave (
    input  i_start, i_hole,
    output o_x, o_y, o_color, o_plot, o_busy, o_done
  );
endinterface

// File: rtl/mole_field_renderer.sv
// Frame sweeper that issues one pixel write per clock, with the first plot one cycle after start.
// There is no backpressure. Defining AUTO_REDRAW_EN also queues a redraw whenever hole differs from the frame snapshot.
module mole_field_renderer #(
  parameter int                   SCREEN_W   = 320,
  parameter int                   SCREEN_H   = 240,
  parameter int                   X_W        = 9,
  parameter int                   Y_W        = 8,
  parameter int                   COLOR_W    = 3,
  parameter int                   NUM_HOLES  = 8,
  parameter int                   HOLE_X0    = 8,
  parameter int                   HOLE_PITCH = 38,
  parameter int                   HOLE_Y     = 110,
  parameter int                   HOLE_SIZE  = 31,
  parameter logic [COLOR_W-1:0]   BG_COLOR   = 3'b010,
  parameter logic [COLOR_W-1:0]   HOLE_COLOR = 3'b110,
  parameter logic [COLOR_W-1:0]   MOLE_COLOR = 3'b101
) (
  input  logic                 clk,
  input  logic                 rst,
  mole_field_renderer_if.slave bus
);
  localparam int XW1 = X_W + 1;
  localparam int YW1 = Y_W + 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);
  localparam logic [YW1-1:0] Y_TOP  = YW1'(HOLE_Y);
  localparam logic [YW1-1:0] Y_BOT  = YW1'(HOLE_Y + HOLE_SIZE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]           r_state;
  logic [NUM_HOLES-1:0] r_snap;
  logic                 r_pending;
  logic [X_W-1:0]       r_x;
  logic [Y_W-1:0]       r_y;
  logic [COLOR_W-1:0]   r_color;
  logic                 r_plot;
  logic                 r_done;

  logic                 w_chg;
  logic                 w_req;
  logic                 w_enter;
  logic                 w_last;
  logic [X_W-1:0]       w_nx;
  logic [Y_W-1:0]       w_ny;
  logic [NUM_HOLES-1:0] w_holes;
  logic [COLOR_W-1:0]   w_color;

`ifdef AUTO_REDRAW_EN
  assign w_chg = (bus.i_hole != r_snap);
`else
  assign w_chg = 1'b0;
`endif

  assign w_req   = bus.i_start | r_pending | w_chg;
  assign w_enter = ((r_state == S_IDLE) || (r_state == S_DONE)) && w_req;
  assign w_last  = (r_x == X_LAST) && (r_y == Y_LAST);
  // The first pixel of a frame is coloured from the live vector, which becomes the snapshot on the same edge.
  assign w_holes = (r_state == S_SWEEP) ? r_snap : bus.i_hole;

  always_comb begin
    w_nx = '0;
    w_ny = '0;
    if (r_state == S_SWEEP) begin
      if (r_x == X_LAST) begin
        w_nx = '0;
        w_ny = r_y + 1'b1;
      end else begin
        w_nx = r_x + 1'b1;
        w_ny = r_y;
      end
    end
  end

  // Scan from the highest hole down so that the lowest-numbered overlapping hole wins.
  always_comb begin
    w_color = BG_COLOR;
    for (int k = NUM_HOLES - 1; k >= 0; k--) begin
      if (({1'b0, w_nx} >= XW1'(HOLE_X0 + k * HOLE_PITCH)) &&
          ({1'b0, w_nx} <= XW1'(HOLE_X0 + k * HOLE_PITCH + HOLE_SIZE - 1)) &&
          ({1'b0, w_ny} >= Y_TOP) && ({1'b0, w_ny} <= Y_BOT)) begin
        w_color = w_holes[k] ? MOLE_COLOR : HOLE_COLOR;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_snap    <= '0;
      r_pending <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_color   <= '0;
      r_plot    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_enter) begin
        r_state   <= S_SWEEP;
        r_snap    <= bus.i_hole;
        r_pending <= 1'b0;
        r_x       <= '0;
        r_y       <= '0;
        r_color   <= w_color;
        r_plot    <= 1'b1;
      end else begin
        case (r_state)
          S_SWEEP: begin
            r_pending <= r_pending | bus.i_start | w_chg;
            if (w_last) begin
              r_state <= S_DONE;
              r_plot  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_x     <= w_nx;
              r_y     <= w_ny;
              r_color <= w_color;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          S_IDLE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.o_x     = r_x;
  assign bus.o_y     = r_y;
  assign bus.o_color = r_color;
  assign bus.o_plot  = r_plot;
  assign bus.o_busy  = (r_state != S_IDLE);
  assign bus.o_done  = r_done;
endmodule

// File: tb/tb_mole_field_renderer.sv
// Directed and random frame checks against a per-pixel reference model on a scaled-down field.
// The scaled field has overlapping holes and a last hole clipped at the right edge, so both of those rules get exercised.
module tb_mole_field_renderer;
  localparam int W   = 48;
  localparam int H   = 20;
  localparam int XW  = 6;
  localparam int YW  = 5;
  localparam int NH  = 8;
  localparam int X0  = 2;
  localparam int P   = 6;
  localparam int HY  = 5;
  localparam int S   = 7;
  localparam int NPIX = W * H;
  localparam logic [2:0] BG   = 3'b010;
  localparam logic [2:0] HOLE = 3'b110;
  localparam logic [2:0] MOLE = 3'b101;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  logic [2:0] fcol [NPIX];

  mole_field_renderer_if #(.X_W(XW), .Y_W(YW), .COLOR_W(3), .NUM_HOLES(NH)) bus ();

  mole_field_renderer #(
    .SCREEN_W(W), .SCREEN_H(H), .X_W(XW), .Y_W(YW), .COLOR_W(3), .NUM_HOLES(NH),
    .HOLE_X0(X0), .HOLE_PITCH(P), .HOLE_Y(HY), .HOLE_SIZE(S),
    .BG_COLOR(BG), .HOLE_COLOR(HOLE), .MOLE_COLOR(MOLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference colour: the first hole (lowest k) whose square contains the pixel decides the colour.
  function automatic logic [2:0] ref_color(input int x, input int y, input logic [NH-1:0] h);
    logic [2:0] c;
    logic       found;
    c     = BG;
    found = 1'b0;
    for (int k = 0; k < NH; k++) begin
      if (!found && x >= X0 + k * P && x <= X0 + k * P + S - 1 && y >= HY && y <= HY + S - 1) begin
        c     = h[k] ? MOLE : HOLE;
        found = 1'b1;
      end
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects the frame-entry edge to be the next one, checks every pixel and the done cycle, and ends in the DONE cycle.
  task automatic run_frame(input logic [NH-1:0] snap, input int chg_idx, input logic [NH-1:0] chg_val,
                           input int st_idx);
    logic [31:0] exp;
    logic [31:0] obs;
    for (int i = 0; i < NPIX; i++) begin
      step();
      bus.i_start = 1'b0;
      exp = {17'b0, 1'b1, XW'(i % W), YW'(i / W), ref_color(i % W, i / W, snap)};
      obs = {17'b0, bus.o_plot, bus.o_x, bus.o_y, bus.o_color};
      fcol[i] = bus.o_color;
      chk($sformatf("pix%0d", i), obs, exp);
      if (i == chg_idx) bus.i_hole = chg_val;
      if (st_idx >= 0 && (i == st_idx || i == st_idx + 7 || i == st_idx + 20)) bus.i_start = 1'b1;
    end
    step();
    bus.i_start = 1'b0;
    chk("done_cycle", {29'b0, bus.o_plot, bus.o_done, bus.o_busy}, 32'b011);
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {20'b0, bus.o_plot, bus.o_done, bus.o_busy, bus.o_x, bus.o_y},
        {20'b0, 3'b000, XW'(W - 1), YW'(H - 1)});
  endtask

  task automatic chk_pix(input string tag, input int x, input int y, input logic [2:0] exp);
    chk(tag, {29'b0, fcol[y * W + x]}, {29'b0, exp});
  endtask

  initial begin
    logic [NH-1:0] h;
    n_cmp  = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_hole  = '0;
    step();
    step();
    chk("reset_out", {17'b0, bus.o_plot, bus.o_busy, bus.o_done, bus.o_x, bus.o_y, bus.o_color}, 32'b0);
    rst = 1'b0;
    step();
    chk("idle_after_reset", {30'b0, bus.o_plot, bus.o_busy}, 32'b0);

    // Empty field: every hole region shows the hole colour.
    bus.i_hole = 8'h00;
    bus.i_start = 1'b1;
    run_frame(8'h00, -1, '0, -1);
    step();
    chk_idle("idle_after_frameA");
    chk_pix("A_hole0_corner", 2, 5, HOLE);
    chk_pix("A_left_of_hole0", 1, 5, BG);
    chk_pix("A_hole_overlap", 8, 11, HOLE);
    chk_pix("A_below_hole", 8, 12, BG);

    // Moles in holes 0 and 7. Hole 7 is clipped by the right edge, and at x=44 hole 6 wins the overlap.
    bus.i_hole = 8'b1000_0001;
    bus.i_start = 1'b1;
    run_frame(8'b1000_0001, -1, '0, -1);
    step();
    chk_idle("idle_after_frameB");
    chk_pix("B_hole0_mole", 2, 5, MOLE);
    chk_pix("B_overlap_hole6", 44, 5, HOLE);
    chk_pix("B_hole7_mole", 45, 11, MOLE);
    chk_pix("B_last_col", 47, 5, MOLE);

    // With only hole 1 occupied, the pixel shared by holes 0 and 1 takes hole 0's empty colour.
    bus.i_hole = 8'h02;
    bus.i_start = 1'b1;
    run_frame(8'h02, -1, '0, -1);
    step();
    chk_pix("C_overlap_low_wins", 8, 5, HOLE);
    chk_pix("C_hole1_mole", 9, 5, MOLE);

    // The hole vector changes mid-frame, but the rest of the frame must keep using the snapshot.
    bus.i_hole = 8'h00;
    bus.i_start = 1'b1;
    run_frame(8'h00, 15 * W, 8'hFF, -1);
`ifdef AUTO_REDRAW_EN
    run_frame(8'hFF, -1, '0, -1);
    step();
    chk_idle("idle_after_auto_frame");
`else
    for (int i = 0; i < 5; i++) begin
      step();
      chk_idle($sformatf("no_auto_redraw%0d", i));
    end
`endif

    // Three start pulses during a sweep merge into exactly one extra frame that begins right after done.
    bus.i_hole = 8'h5A;
    bus.i_start = 1'b1;
    run_frame(8'h5A, -1, '0, 100);
    run_frame(8'h5A, -1, '0, -1);
    step();
    chk_idle("idle_after_merge");
    step();
    chk_idle("idle_after_merge2");

    // Random hole patterns. Odd iterations restart directly from the DONE cycle.
    bus.i_start = 1'b1;
    h = NH'($urandom);
    bus.i_hole = h;
    for (int r = 0; r < 4; r++) begin
      run_frame(h, -1, '0, -1);
      h = NH'($urandom);
      if (r % 2 == 1) begin
        step();
        chk_idle($sformatf("idle_rand%0d", r));
      end
      bus.i_hole = h;
      bus.i_start = 1'b1;
    end

    // Reset arrives mid-sweep: the outputs must clear asynchronously, and the frame must not resume afterwards.
    for (int i = 0; i < 500; i++) begin
      step();
      bus.i_start = 1'b0;
    end
    chk("pre_reset_plot", {31'b0, bus.o_plot}, 32'd1);
    bus.i_hole = '0;
    rst = 1'b1;
    #1;
    chk("async_reset", {17'b0, bus.o_plot, bus.o_busy, bus.o_done, bus.o_x, bus.o_y, bus.o_color}, 32'b0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("post_reset_idle%0d", i), {30'b0, bus.o_plot, bus.o_busy}, 32'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
